// File: rtl/fbs_sequencer_pkg.sv
// Shared constants for the f-register backup sequencer: state encodings,
// fault codes and a small state-decode helper.
package fbs_sequencer_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SAVE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // fault_code values
    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_OVERFLOW  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_TIMEOUT   = 2'd3;

    // True while a transfer to or from fbs is in flight
    function automatic logic state_busy(input logic [1:0] st);
        return (st == ST_SAVE) || (st == ST_LOAD);
    endfunction

endpackage

// File: rtl/fbs_tmo_ctr.sv
// Restore timeout counter: counts enabled cycles and flags the cycle that is
// the LIMIT-th enabled cycle since the last clear.
module fbs_tmo_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Count completed enabled cycles; holds at LAST so it can never wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (clear) begin
            count <= {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/fbs_sequencer.sv
// Sequences fbs backup/restore for CALL/RET: one-cycle backup pulses, held
// restore strobe, stack depth tracking, pipeline stall and fault trapping.
module fbs_sequencer
    import fbs_sequencer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = 5,
    parameter int RST_TMO = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic               clear_fault,
    input  logic               fbs_restore_out,
    output logic               fbs_backup,
    output logic               fbs_restore,
    output logic               call_ack,
    output logic               ret_ack,
    output logic               stall,
    output logic [DEPTH_W-1:0] depth,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [1:0]         next_code;
    logic [DEPTH_W-1:0] next_depth;
    logic               tmo_expired;
    logic               in_load;
    logic               call_ok;
    logic               ret_ok;

    assign in_load = (state == ST_LOAD);

    // Counter is cleared outside LOAD and on the completing cycle so every
    // restore starts from zero
    fbs_tmo_ctr #(
        .LIMIT (RST_TMO)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_load || fbs_restore_out),
        .enable  (in_load),
        .expired (tmo_expired)
    );

    // Legal requests as seen from IDLE; call has priority over ret
    assign call_ok = call_req && (depth != DEPTH_MAX);
    assign ret_ok  = ret_req && !call_req && (depth != DEPTH_ZERO);

    // Next-state, next-depth and fault-code decode
    always_comb begin
        next_state = state;
        next_code  = fault_code;
        next_depth = depth;
        case (state)
            ST_IDLE: begin
                if (call_req) begin
                    if (depth == DEPTH_MAX) begin
                        next_state = ST_FAULT;
                        next_code  = FC_OVERFLOW;
                    end else begin
                        next_state = ST_SAVE;
                    end
                end else if (ret_req) begin
                    if (depth == DEPTH_ZERO) begin
                        next_state = ST_FAULT;
                        next_code  = FC_UNDERFLOW;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_SAVE: begin
                next_state = ST_IDLE;
                next_depth = depth + DEPTH_ONE;
            end
            ST_LOAD: begin
                if (fbs_restore_out) begin
                    next_state = ST_IDLE;
                    next_depth = depth - DEPTH_ONE;
                end else if (tmo_expired) begin
                    next_state = ST_FAULT;
                    next_code  = FC_TIMEOUT;
                end else begin
                    next_state = ST_LOAD;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    next_state = ST_IDLE;
                    next_code  = FC_NONE;
                end else begin
                    next_state = ST_FAULT;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_code  = FC_NONE;
            end
        endcase
    end

    // State, depth and fault-code registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            depth      <= DEPTH_ZERO;
            fault_code <= FC_NONE;
        end else begin
            state      <= next_state;
            depth      <= next_depth;
            fault_code <= next_code;
        end
    end

    // Strobes are decoded from the state register so reset kills them at once
    assign fbs_backup  = (state == ST_SAVE);
    assign call_ack    = (state == ST_SAVE);
    assign fbs_restore = in_load;
    assign ret_ack     = in_load && fbs_restore_out;
    assign fault       = (state == ST_FAULT);
    assign stall       = state_busy(state) || ((state == ST_IDLE) && (call_ok || ret_ok));

endmodule
